muldiv4_seq: RTL and testbench
==============================

MULDIV4_SEQ -- requirements
Module: muldiv4_seq

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 Port start  input  1: request pulse, sampled only in IDLE.
REQ-003 Port op  input  1: 0 = unsigned multiply, 1 = unsigned divide; sampled with start.
REQ-004 Ports a, b  input  4 each: operands (multiplicand/multiplier, dividend/divisor); sampled with start.
REQ-005 Port busy  output  1: high while an operation iterates (RUN).
REQ-006 Port done  output  1: one-cycle pulse, results valid.
REQ-007 Port result_hi  output  4: product[7:4] (mul) or remainder (div).
REQ-008 Port result_lo  output  4: product[3:0] (mul) or quotient (div).
REQ-009 Port div_zero  output  1: divide-by-zero flag, updated at each done.

Function
REQ-010 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-011 In IDLE, start=1 at edge N SHALL latch op, a, b, clear the step counter (2 bits), and enter RUN, except divide with b=0, which enters DONE.
REQ-012 RUN SHALL take exactly 4 cycles (edges N+1..N+4), one iteration per edge, then enter DONE.
REQ-013 DONE SHALL last one cycle with done=1, then return to IDLE; start during RUN or DONE SHALL be ignored.
REQ-014 Multiply: {P_hi,P_lo} init {0,a}; per step, if P_lo[0]=1, sum = P_hi + b (5-bit, with carry) else sum = {0,P_hi}; {P_hi,P_lo} <= {sum,P_lo} >> 1 (9-bit shift).
REQ-015 Divide (restoring): {R,Q} init {0,a}; per step shift {R,Q} left 1 (R 5 bits), trial = R - b (5-bit); if no borrow R <= trial and Q[0] <= 1, else R kept and Q[0] <= 0.
REQ-016 All add/subtract SHALL go through the single shared 5-bit add/sub unit; its mode select is 0 for multiply steps and 1 for divide steps.
REQ-017 result_hi/result_lo/div_zero SHALL update only on the edge entering DONE and hold until the next such edge.
REQ-018 Divide with b=0 SHALL produce result_lo=4'hF, result_hi=a, div_zero=1, done one cycle after start; any other completion SHALL clear div_zero.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both registered or decoded from state, without glitch-dependent logic.
REQ-020 Latched operands SHALL be unaffected by a, b, op changes after acceptance.

Reset
REQ-021 rst=1 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, result_hi=0, result_lo=0, div_zero=0, and clear internal registers.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after rst deassertion SHALL be accepted normally.

Structure
REQ-023 A shared package SHALL hold state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), OP_MUL=1'b0, OP_DIV=1'b1, and WIDTH=4.
REQ-024 The shared adder SHALL be a separate combinational sub-module addsub5 (inputs x[4:0], y[4:0], sub; outputs s[4:0], cout), instantiated once.
REQ-025 Unused state encoding 2'd3 SHALL recover to IDLE.

Verification
REQ-026 Mul 13x11: op=0, a=4'hD, b=4'hB, start at edge N -> busy N+1..N+4, done in cycle after N+4, result_hi=4'h8, result_lo=4'hF, div_zero=0.
REQ-027 Div 13/3: op=1, a=4'hD, b=4'h3 -> after 4 RUN cycles result_lo=4'h4, result_hi=4'h1.
REQ-028 Div by zero: op=1, a=4'h9, b=0 -> done in cycle after start edge, result_lo=4'hF, result_hi=4'h9, div_zero=1, busy never 1.
REQ-029 Boundary: mul 15x15 -> 8'hE1; div 15/1 -> Q=4'hF, R=0; div 2/7 -> Q=0, R=2.
REQ-030 Start pulsed during RUN with different operands -> ignored, original result delivered; back-to-back start in cycle after done accepted.
REQ-031 rst asserted at RUN step 2 -> outputs 0 asynchronously, no done; subsequent mul 3x5 yields 8'h0F.

Source files
------------

// File: rtl/muldiv4_seq_pkg.sv
// Shared definitions for the 4-bit sequential multiply/divide unit:
// state encodings, operation codes and the operand width.
package muldiv4_seq_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv4_seq_addsub5.sv
// Shared 5-bit adder/subtractor: s = x + y (sub=0) or x - y (sub=1).
// For subtraction cout=1 means no borrow (x >= y).
module addsub5
  import muldiv4_seq_pkg::*;
(
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] s,
  output logic           cout
);

  logic [WIDTH+1:0] sum_s;

  assign sum_s = {1'b0, x} + {1'b0, y ^ {(WIDTH+1){sub}}} + {{(WIDTH+1){1'b0}}, sub};
  assign s     = sum_s[WIDTH:0];
  assign cout  = sum_s[WIDTH+1];

endmodule

// File: rtl/muldiv4_seq.sv
// 4-bit sequential unsigned multiplier (shift-add) and restoring divider,
// four iterations per operation through one shared add/sub unit.
module muldiv4_seq
  import muldiv4_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_zero
);

  state_t           state_r;
  logic             op_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;   // P_hi for multiply, remainder for divide
  logic [WIDTH-1:0] lo_r;    // P_lo for multiply, quotient for divide
  logic [1:0]       cnt_r;

  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   x_s;
  logic [WIDTH:0]   y_s;
  logic [WIDTH:0]   s_s;
  logic             cout_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] nacc_s;
  logic [WIDTH-1:0] nlo_s;

  // Operand select for the shared adder
  always_comb begin
    shift_s = {acc_r, lo_r[WIDTH-1]};
    y_s     = {1'b0, b_r};
    if (op_r == OP_DIV) begin
      x_s = shift_s;
    end else begin
      x_s = {1'b0, acc_r};
    end
  end

  addsub5 u_addsub5 (
    .x    (x_s),
    .y    (y_s),
    .sub  (op_r),
    .s    (s_s),
    .cout (cout_s)
  );

  // Next accumulator/low word for one iteration of the current operation
  always_comb begin
    sum_s  = {1'b0, acc_r};
    nacc_s = acc_r;
    nlo_s  = lo_r;
    if (op_r == OP_DIV) begin
      if (cout_s) begin
        nacc_s = s_s[WIDTH-1:0];
        nlo_s  = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        nacc_s = shift_s[WIDTH-1:0];
        nlo_s  = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo_r[0]) begin
        sum_s = s_s;
      end else begin
        sum_s = {1'b0, acc_r};
      end
      nacc_s = sum_s[WIDTH:1];
      nlo_s  = {sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= OP_MUL;
      b_r       <= '0;
      acc_r     <= '0;
      lo_r      <= '0;
      cnt_r     <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            b_r   <= b;
            cnt_r <= 2'd0;
            acc_r <= '0;
            lo_r  <= a;
            if ((op == OP_DIV) && (b == 4'd0)) begin
              state_r   <= DONE;
              done      <= 1'b1;
              result_hi <= a;
              result_lo <= 4'hF;
              div_zero  <= 1'b1;
            end else begin
              state_r <= RUN;
              busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_r <= nacc_s;
          lo_r  <= nlo_s;
          cnt_r <= cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            state_r   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result_hi <= nacc_s;
            result_lo <= nlo_s;
            div_zero  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv4_seq.sv
// Self-checking bench for muldiv4_seq: arithmetic reference model compared
// every cycle, plus directed operations with literal expected results.
module tb_muldiv4_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] result_hi;
  logic [3:0] result_lo;
  logic       div_zero;

  int checks;
  int errors;

  muldiv4_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining iterations, pending done, and results by plain arithmetic
  int   m_left;
  bit   m_done;
  int   m_hi, m_lo;
  bit   m_dz;
  int   m_a, m_b;
  bit   m_op;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_done <= 1'b0; m_hi <= 0; m_lo <= 0; m_dz <= 1'b0;
      m_a <= 0; m_b <= 0; m_op <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        if (op && b == 4'd0) begin
          m_done <= 1'b1; m_hi <= int'(a); m_lo <= 15; m_dz <= 1'b1;
        end else begin
          m_left <= 4; m_a <= int'(a); m_b <= int'(b); m_op <= op;
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_dz   <= 1'b0;
        if (m_op) begin
          m_hi <= m_a % m_b; m_lo <= m_a / m_b;
        end else begin
          m_hi <= (m_a * m_b) / 16; m_lo <= (m_a * m_b) % 16;
        end
      end
    end
  end

  bit cmp_en;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("busy", int'(busy), int'(m_left != 0));
      check("done", int'(done), int'(m_done));
      check("result_hi", int'(result_hi), m_hi);
      check("result_lo", int'(result_lo), m_lo);
      check("div_zero", int'(div_zero), int'(m_dz));
    end
  end

  // Issue one operation at a negedge; optionally poke start mid-run or reset mid-run.
  task automatic run_op(input bit o, input logic [3:0] av, input logic [3:0] bv,
                        input int exp_hi, input int exp_lo, input int exp_dz,
                        input int exp_lat, input bit poke, input bit do_rst,
                        input string name);
    int k;
    bit seen;
    seen = 1'b0;
    op = o; a = av; b = bv; start = 1'b1;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; a = ~av; b = ~bv; op = ~o;
      end
      if (poke && k == 2) begin
        start = 1'b1; a = 4'h1; b = 4'h1;
      end
      if (poke && k == 3) start = 1'b0;
      if (do_rst && k == 2) begin
        #2 rst = 1'b1;
        #1;
        check({name, "_rst_busy"}, int'(busy), 0);
        check({name, "_rst_done"}, int'(done), 0);
        check({name, "_rst_hi"}, int'(result_hi), 0);
        check({name, "_rst_lo"}, int'(result_lo), 0);
        check({name, "_rst_dz"}, int'(div_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          check({name, "_no_done"}, int'(done), 0);
        end
        return;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_seen"}, int'(seen), 1);
    check({name, "_latency"}, k, exp_lat);
    check({name, "_hi"}, int'(result_hi), exp_hi);
    check({name, "_lo"}, int'(result_lo), exp_lo);
    check({name, "_dz"}, int'(div_zero), exp_dz);
    @(negedge clk);
    check({name, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    checks = 0; errors = 0; cmp_en = 1'b0;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = 4'h0; b = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_hi", int'(result_hi), 0);
    check("reset_lo", int'(result_lo), 0);
    check("reset_dz", int'(div_zero), 0);
    cmp_en = 1'b1;

    run_op(1'b0, 4'hD, 4'hB, 4'h8, 4'hF, 0, 5, 1'b0, 1'b0, "mul13x11");
    run_op(1'b1, 4'hD, 4'h3, 4'h1, 4'h4, 0, 5, 1'b0, 1'b0, "div13by3");
    run_op(1'b1, 4'h9, 4'h0, 4'h9, 4'hF, 1, 1, 1'b0, 1'b0, "div9by0");
    run_op(1'b0, 4'hF, 4'hF, 4'hE, 4'h1, 0, 5, 1'b0, 1'b0, "mul15x15");
    run_op(1'b1, 4'hF, 4'h1, 4'h0, 4'hF, 0, 5, 1'b0, 1'b0, "div15by1");
    run_op(1'b1, 4'h2, 4'h7, 4'h2, 4'h0, 0, 5, 1'b0, 1'b0, "div2by7");
    run_op(1'b0, 4'h6, 4'h7, 4'h2, 4'hA, 0, 5, 1'b1, 1'b0, "mul6x7_poke");
    run_op(1'b1, 4'hE, 4'h4, 4'h2, 4'h3, 0, 5, 1'b0, 1'b0, "div14by4_b2b");
    run_op(1'b0, 4'h0, 4'h9, 4'h0, 4'h0, 0, 5, 1'b0, 1'b0, "mul0x9");
    run_op(1'b0, 4'hC, 4'h9, 4'h0, 4'h0, 0, 5, 1'b0, 1'b1, "mul12x9_rst");
    run_op(1'b0, 4'h3, 4'h5, 4'h0, 4'hF, 0, 5, 1'b0, 1'b0, "mul3x5");
    run_op(1'b1, 4'hB, 4'hB, 4'h0, 4'h1, 0, 5, 1'b0, 1'b0, "div11by11");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
